// File: rtl/dff_char_stim_gen.sv
// ----------------------------------------------------------------------------
// dff_char_stim_gen
//
// Stimulus transmitter and response checker for a bank of async-reset D
// flip-flops (dffrnq family). Each run pulls the bank's reset low for
// RST_CYCLES clocks and checks that Q cleared. It then drives num_vec
// pseudo-random vectors from a 16-bit LFSR onto D and checks every Q one
// clock after the bank captured it.
//
// Ports
//   CLK      in   rising-edge clock, shared with the DUT bank
//   RN       in   asynchronous active-low reset of this block
//   start    in   one-cycle pulse, begins a run from IDLE or DONE
//   abort    in   synchronous return to IDLE (wins over start)
//   num_vec  in   vectors per run, latched on start (0 = reset check only)
//   DUT_Q    in   Q outputs of the DUT bank
//   DUT_D    out  registered D drive to the DUT bank
//   DUT_RN   out  registered active-low reset drive to the DUT bank
//   busy     out  high in every state except IDLE and DONE
//   done     out  high in DONE
//   pass     out  high in DONE when no mismatch was seen
//   err_cnt  out  mismatch count, saturating at all-ones
// ----------------------------------------------------------------------------
module dff_char_stim_gen #(
    parameter int          WIDTH      = 8,
    parameter logic [15:0] SEED       = 16'h0001,
    parameter int          RST_CYCLES = 3,
    parameter int          CNT_W      = 16
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] num_vec,
    input  logic [WIDTH-1:0] DUT_Q,
    output logic [WIDTH-1:0] DUT_D,
    output logic             DUT_RN,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_RST_ASSERT  = 3'd1,
        S_RST_RELEASE = 3'd2,
        S_DRIVE       = 3'd3,
        S_DRAIN       = 3'd4,
        S_DONE        = 3'd5
    } state_t;

    // An all-zero seed would lock the LFSR, so it is replaced.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;
    localparam int          RC_W     = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYCLES - 1);

    state_t           r_state;
    state_t           w_next;
    logic [RC_W-1:0]  r_rst_cnt;
    logic [CNT_W-1:0] r_vec_cnt;
    logic [CNT_W-1:0] r_num_vec;
    logic [15:0]      r_lfsr;
    logic [WIDTH-1:0] r_dut_d;
    logic             r_dut_rn;
    logic [WIDTH-1:0] r_exp;
    logic             r_exp_vld;
    logic [CNT_W-1:0] r_err_cnt;

    logic             w_start;
    logic             w_load;
    logic             w_rst_chk;
    logic             w_dat_chk;
    logic             w_err_hit;
    logic             w_busy;
    logic             w_done;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // ---- state register ----
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ---- next-state logic ----
    always_comb begin
        w_next = r_state;
        if (abort) begin
            w_next = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE:        if (start) w_next = S_RST_ASSERT;
                S_RST_ASSERT:  if (r_rst_cnt == RC_LAST) w_next = S_RST_RELEASE;
                S_RST_RELEASE: w_next = (r_num_vec != '0) ? S_DRIVE : S_DONE;
                S_DRIVE:       if (r_vec_cnt == r_num_vec) w_next = S_DRAIN;
                S_DRAIN:       w_next = S_DONE;
                S_DONE:        if (start) w_next = S_RST_ASSERT;
                default:       w_next = S_IDLE;
            endcase
        end
    end

    // ---- output / control decode ----
    always_comb begin
        w_busy    = (r_state != S_IDLE) && (r_state != S_DONE);
        w_done    = (r_state == S_DONE);
        w_start   = ((r_state == S_IDLE) || (r_state == S_DONE)) && (w_next == S_RST_ASSERT);
        // DUT_D is loaded on entry to each DRIVE cycle, so the bank captures
        // the vector at the end of that cycle and Q is checked one cycle later.
        w_load    = (w_next == S_DRIVE);
        w_rst_chk = (r_state == S_RST_ASSERT) && (r_rst_cnt == RC_LAST);
        w_dat_chk = r_exp_vld && ((r_state == S_DRIVE) || (r_state == S_DRAIN));
        // A compare landing in an aborted cycle is discarded.
        w_err_hit = !abort && ((w_rst_chk && (DUT_Q != '0)) ||
                               (w_dat_chk && (DUT_Q != r_exp)));
    end

    // ---- stage p0: sequencing counters, LFSR and DUT drive ----
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            r_rst_cnt <= '0;
            r_vec_cnt <= '0;
            r_num_vec <= '0;
            r_lfsr    <= SEED_EFF;
            r_dut_d   <= '0;
            r_dut_rn  <= 1'b1;
            r_exp_vld <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_dut_rn <= (w_next != S_RST_ASSERT);

            if (w_start) begin
                r_rst_cnt <= '0;
                r_num_vec <= num_vec;
            end else if (r_state == S_RST_ASSERT) begin
                r_rst_cnt <= r_rst_cnt + 1'b1;
            end

            if (w_start) begin
                r_vec_cnt <= '0;
                r_lfsr    <= SEED_EFF;
            end else if (w_load) begin
                r_vec_cnt <= r_vec_cnt + CNT_W'(1);
                r_lfsr    <= lfsr_step(r_lfsr);
            end

            // D holds its last vector through DRAIN and DONE.
            unique case (w_next)
                S_DRIVE:        r_dut_d <= r_lfsr[WIDTH-1:0];
                S_DRAIN,
                S_DONE:         r_dut_d <= r_dut_d;
                default:        r_dut_d <= '0;
            endcase

            if ((w_next == S_IDLE) || (w_next == S_RST_ASSERT) || (w_next == S_RST_RELEASE)) begin
                r_exp_vld <= 1'b0;
            end else if (r_state == S_DRIVE) begin
                r_exp_vld <= 1'b1;
            end

            if (w_start) begin
                r_err_cnt <= '0;
            end else if (w_err_hit) begin
                r_err_cnt <= sat_inc(r_err_cnt);
            end
        end
    end

    // ---- stage p1: expected Q, the vector the bank is capturing now ----
    always_ff @(posedge CLK) begin
        if (r_state == S_DRIVE) begin
            r_exp <= r_dut_d;
        end
    end

    assign DUT_D   = r_dut_d;
    assign DUT_RN  = r_dut_rn;
    assign busy    = w_busy;
    assign done    = w_done;
    assign pass    = w_done && (r_err_cnt == '0);
    assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_dff_char_stim_gen.sv
module tb_dff_char_stim_gen;

    logic        CLK;
    // main instance: WIDTH 8, SEED 1, CNT_W 16
    logic        RN;
    logic        start;
    logic        abort;
    logic [15:0] num_vec;
    logic [7:0]  DUT_Q;
    logic [7:0]  DUT_D;
    logic        DUT_RN;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] err_cnt;
    int          mode;

    // second instance: SEED 0 (-> ACE1), CNT_W 2
    logic        RN2;
    logic        start2;
    logic        abort2;
    logic [1:0]  nv2;
    logic [7:0]  q2;
    logic [7:0]  d2;
    logic        rn2o;
    logic        busy2;
    logic        done2;
    logic        pass2;
    logic [1:0]  err2;

    logic [7:0]  q_ideal;
    int          tests;
    int          fails;

    // Hand-computed from lfsr_next = {lfsr[14:0], b15^b13^b12^b10}, seed 0001:
    // 0001 0002 0004 0008 0010 0020 0040 0080 0100 0200 0400 0801
    logic [7:0]  exp_vec [12] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20,
                                  8'h40, 8'h80, 8'h00, 8'h00, 8'h00, 8'h01};

    dff_char_stim_gen #(.WIDTH(8), .SEED(16'h0001), .RST_CYCLES(3), .CNT_W(16)) u0 (
        .CLK(CLK), .RN(RN), .start(start), .abort(abort), .num_vec(num_vec),
        .DUT_Q(DUT_Q), .DUT_D(DUT_D), .DUT_RN(DUT_RN), .busy(busy),
        .done(done), .pass(pass), .err_cnt(err_cnt)
    );

    dff_char_stim_gen #(.WIDTH(8), .SEED(16'h0000), .RST_CYCLES(3), .CNT_W(2)) u2 (
        .CLK(CLK), .RN(RN2), .start(start2), .abort(abort2), .num_vec(nv2),
        .DUT_Q(q2), .DUT_D(d2), .DUT_RN(rn2o), .busy(busy2),
        .done(done2), .pass(pass2), .err_cnt(err2)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Ideal DUT bank: Q <= D, async clear on DUT_RN.
    always @(posedge CLK or negedge DUT_RN) begin
        if (!DUT_RN) q_ideal <= 8'h00;
        else         q_ideal <= DUT_D;
    end

    always_comb begin
        case (mode)
            0:       DUT_Q = q_ideal;
            1:       DUT_Q = q_ideal | 8'h08;  // bit 3 stuck at 1
            2:       DUT_Q = 8'hAA;            // ignores reset, holds AA
            default: DUT_Q = 8'h00;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Pulse start for one cycle; returns at the negedge after the start edge.
    task automatic go0(input logic [15:0] nv);
        num_vec = nv;
        start   = 1'b1;
        @(negedge CLK);
        start   = 1'b0;
    endtask

    // Counts clock edges after the start edge until done (bounded).
    task automatic wait_done0(output int n);
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(negedge CLK);
            n++;
        end
    endtask

    task automatic wait_done2(output int n);
        n = 0;
        while (done2 !== 1'b1 && n < 100) begin
            @(negedge CLK);
            n++;
        end
    endtask

    initial begin
        int n;
        int low;
        logic [15:0] err_hold;

        tests   = 0;
        fails   = 0;
        RN      = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        num_vec = '0;
        mode    = 0;
        RN2     = 1'b0;
        start2  = 1'b0;
        abort2  = 1'b0;
        nv2     = '0;
        q2      = 8'h00;

        // Reset state
        @(negedge CLK);
        @(negedge CLK);
        chk("rst_DUT_RN", DUT_RN, 1);
        chk("rst_DUT_D", DUT_D, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_err", err_cnt, 0);
        RN  = 1'b1;
        RN2 = 1'b1;
        @(negedge CLK);
        chk("idle_busy", busy, 0);

        // Ideal DUT, 12 vectors
        mode = 0;
        go0(16'd12);
        low = 0;
        for (int k = 0; k <= 17; k++) begin
            if (DUT_RN === 1'b0) low++;
            if (k == 1) chk("busy_run", busy, 1);
            if (k >= 4 && k <= 15) chk($sformatf("vec%0d", k - 3), DUT_D, exp_vec[k-4]);
            if (k == 16) chk("drain_hold", DUT_D, exp_vec[11]);
            if (k == 16) chk("done_early", done, 0);
            if (k < 17) @(negedge CLK);
        end
        chk("rn_low_cycles", low, 3);
        chk("t1_done", done, 1);
        chk("t1_pass", pass, 1);
        chk("t1_err", err_cnt, 0);
        chk("t1_busy", busy, 0);

        // Bit 3 stuck at 1, 4 vectors: reset fail + 01,02,04 fail, 08 ok
        mode = 1;
        go0(16'd4);
        wait_done0(n);
        chk("t2_latency", n, 9);
        chk("t2_err", err_cnt, 4);
        chk("t2_pass", pass, 0);

        // DUT ignores reset (Q=AA), reset check only
        mode = 2;
        go0(16'd0);
        wait_done0(n);
        chk("t3_latency", n, 4);
        chk("t3_err", err_cnt, 1);
        chk("t3_pass", pass, 0);

        // abort + start in the 3rd DRIVE cycle
        mode = 1;
        go0(16'd12);
        for (int k = 0; k < 6; k++) @(negedge CLK);
        err_hold = err_cnt;
        chk("t4_err_before", err_hold, 2);
        abort = 1'b1;
        start = 1'b1;
        @(negedge CLK);
        abort = 1'b0;
        start = 1'b0;
        chk("t4_busy", busy, 0);
        chk("t4_done", done, 0);
        chk("t4_DUT_D", DUT_D, 0);
        chk("t4_DUT_RN", DUT_RN, 1);
        chk("t4_err_kept", err_cnt, 2);
        @(negedge CLK);
        chk("t4_stay_idle", busy, 0);

        // restart after abort begins again at 01
        mode = 0;
        go0(16'd2);
        for (int k = 0; k < 4; k++) @(negedge CLK);
        chk("t4_restart_v1", DUT_D, 8'h01);
        @(negedge CLK);
        chk("t4_restart_v2", DUT_D, 8'h02);
        wait_done0(n);
        chk("t4_restart_lat", n + 5, 7);
        chk("t4_restart_err", err_cnt, 0);
        chk("t4_restart_pass", pass, 1);

        // RN pulsed low mid-DRIVE
        mode = 1;
        go0(16'd12);
        for (int k = 0; k < 6; k++) @(negedge CLK);
        chk("t5_pre_D", DUT_D, 8'h04);
        chk("t5_pre_err", err_cnt, 2);
        RN = 1'b0;
        #1;
        chk("t5_async_DUT_RN", DUT_RN, 1);
        chk("t5_async_DUT_D", DUT_D, 0);
        chk("t5_async_err", err_cnt, 0);
        chk("t5_async_busy", busy, 0);
        @(negedge CLK);
        RN = 1'b1;
        @(negedge CLK);
        chk("t5_after_busy", busy, 0);
        chk("t5_after_done", done, 0);

        // SEED 0 instance, CNT_W 2, Q stuck at 0, 3 vectors
        nv2    = 2'd3;
        start2 = 1'b1;
        @(negedge CLK);
        start2 = 1'b0;
        for (int k = 0; k < 4; k++) @(negedge CLK);
        chk("t6_first_vec", d2, 8'hE1);
        @(negedge CLK);
        chk("t6_second_vec", d2, 8'hC3);
        wait_done2(n);
        chk("t6_latency", n + 5, 8);
        chk("t6_err", err2, 3);
        chk("t6_pass", pass2, 0);

        // Q stuck at FF: reset fail + 3 vector fails = 4 errors, saturates at 3
        q2     = 8'hFF;
        start2 = 1'b1;
        @(negedge CLK);
        start2 = 1'b0;
        for (int k = 0; k < 4; k++) @(negedge CLK);
        chk("t6b_first_vec", d2, 8'hE1);
        wait_done2(n);
        chk("t6b_err_sat", err2, 3);
        chk("t6b_pass", pass2, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
